// File: rtl/bit_serial_alu_seq.sv
// Bit-serial word ALU sequencer: drives an external combinational 1-bit ALU cell
// LSB first, one bit per clock, closing the carry loop through carry_q.
module bit_serial_alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_carry_in,
    output logic [3:0]       alu_op,
    input  logic             alu_result,
    input  logic             alu_carry_out
);

    localparam int unsigned    CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
    localparam logic [3:0]     OP_ADD = 4'b0010;
    localparam logic [3:0]     OP_SUB = 4'b0110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [3:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             arith;
    logic [WIDTH-1:0] res_next;

    assign arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign res_next = {alu_result, res_sh[WIDTH-1:1]};
    assign result   = res_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        done         = 1'b0;
        alu_a        = 1'b0;
        alu_b        = 1'b0;
        alu_carry_in = 1'b0;
        alu_op       = 4'b0000;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy         = 1'b1;
                alu_a        = a_sh[0];
                alu_b        = b_sh[0];
                alu_carry_in = carry_q;
                alu_op       = op_q;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_q      <= 4'b0000;
            cnt       <= '0;
            carry_q   <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh      <= a_in;
            b_sh      <= b_in;
            op_q      <= op;
            cnt       <= '0;
            res_sh    <= '0;
            carry_q   <= (op == OP_SUB);
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (state == RUN) begin
            res_sh <= res_next;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            cnt    <= cnt + 1'b1;
            if (arith) carry_q <= alu_carry_out;
            // carry_q still holds the carry into the MSB here, giving signed overflow
            if (cnt == LAST) begin
                carry_out <= arith & alu_carry_out;
                overflow  <= arith & (carry_q ^ alu_carry_out);
                zero      <= (res_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Scoreboard bench for bit_serial_alu_seq wired to a behavioural 1-bit ALU cell;
// expected words come from whole-word arithmetic on the operands.
module tb_bit_serial_alu_seq;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       op = 4'b0000;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy, done, carry_out, overflow, zero;
    logic [WIDTH-1:0] result;
    logic             alu_a, alu_b, alu_carry_in, alu_result, alu_carry_out;
    logic [3:0]       alu_op;

    bit_serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero), .alu_a(alu_a), .alu_b(alu_b),
        .alu_carry_in(alu_carry_in), .alu_op(alu_op), .alu_result(alu_result),
        .alu_carry_out(alu_carry_out)
    );

    always #5 clk = ~clk;

    // 1-bit cell: SUB inverts b internally; carry is always the full-adder carry
    logic cell_b;
    always_comb begin
        cell_b        = (alu_op == 4'b0110) ? ~alu_b : alu_b;
        alu_carry_out = (alu_a & cell_b) | (alu_carry_in & (alu_a ^ cell_b));
        case (alu_op)
            4'b0000:          alu_result = alu_a & alu_b;
            4'b0001:          alu_result = alu_a | alu_b;
            4'b0010, 4'b0110: alu_result = alu_a ^ cell_b ^ alu_carry_in;
            4'b1100:          alu_result = ~(alu_a | alu_b);
            default:          alu_result = alu_a ^ alu_b ^ alu_carry_in;
        endcase
    end

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
        int unsigned      edge_no;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned edge_cnt = 0;
    logic [WIDTH-1:0] last_r = '0;
    logic        last_z = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        exp_t      e;
        logic [8:0] s;
        e.c = 1'b0;
        e.v = 1'b0;
        e.edge_no = 0;
        case (o)
            4'b0010: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[7:0];
                e.c = s[8];
                e.v = (a[7] == b[7]) && (e.r[7] != a[7]);
            end
            4'b0110: begin
                e.r = a - b;
                e.c = (a >= b);
                e.v = (a[7] != b[7]) && (e.r[7] != a[7]);
            end
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b1100: e.r = ~(a | b);
            default: e.r = a ^ b;
        endcase
        e.z = (e.r == 8'h00);
        return e;
    endfunction

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", {24'b0, result}, {24'b0, e.r});
                chk("carry_out", {31'b0, carry_out}, {31'b0, e.c});
                chk("overflow", {31'b0, overflow}, {31'b0, e.v});
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("done_edge", edge_cnt, e.edge_no);
                chk("busy_in_done", {31'b0, busy}, 32'd1);
                last_r = e.r;
                last_z = e.z;
            end
        end
        prev_done <= rst_n && done;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        wait_idle();
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        e = model(o, a, b);
        e.edge_no = edge_cnt + WIDTH;
        sb.push_back(e);
        chk("busy_rise", {31'b0, busy}, 32'd1);
        start = 1'b0;
        op = 4'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
    endtask

    task automatic check_hold();
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold_result", {24'b0, result}, {24'b0, last_r});
        chk("hold_zero", {31'b0, zero}, {31'b0, last_z});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t        e;
        int unsigned k;
        logic [3:0]  ops[6];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0011};

        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", {24'b0, result}, 32'd0);
        chk("rst_flags", {29'b0, carry_out, overflow, zero}, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(4'b0010, 8'h5A, 8'h3C);
        do_op(4'b0110, 8'h10, 8'h20);
        do_op(4'b0110, 8'h33, 8'h33);
        check_hold();
        do_op(4'b0000, 8'hF0, 8'h3C);
        do_op(4'b0001, 8'hF0, 8'h0C);
        do_op(4'b1100, 8'hF0, 8'h0F);
        check_hold();

        // start during RUN must be ignored
        do_op(4'b0010, 8'hFF, 8'h01);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 4'b0001; a_in = 8'h11; b_in = 8'h22;
        @(negedge clk);
        start = 1'b0;
        check_hold();

        // asynchronous reset mid-RUN abandons the operation
        do_op(4'b0010, 8'h12, 8'h34);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        e = sb.pop_back();
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", {24'b0, result}, 32'd0);
        chk("midrst_flags", {29'b0, carry_out, overflow, zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(4'b0010, 8'h01, 8'h01);

        // back-to-back with start held high
        wait_idle();
        op = 4'b0010; a_in = 8'h01; b_in = 8'h02; start = 1'b1;
        @(posedge clk); #1;
        k = edge_cnt;
        e = model(4'b0010, 8'h01, 8'h02); e.edge_no = k + WIDTH;      sb.push_back(e);
        e = model(4'b0010, 8'h03, 8'h04); e.edge_no = k + 2*WIDTH + 2; sb.push_back(e);
        a_in = 8'h03; b_in = 8'h04;
        repeat (WIDTH + 3) @(posedge clk);
        #1 start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            do_op(ops[$urandom_range(0, 5)], 8'($urandom), 8'($urandom));
        end
        do_op(4'b0010, 8'h7F, 8'h01);
        do_op(4'b0110, 8'h80, 8'h01);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
